alu_serial_port: RTL and testbench
==================================

// Module: alu_serial_port
// PURPOSE
// Other end of the ALU's 2-bit serial datapath. Converts byte-wide memory
// traffic into the LSB-first NSHIFT-bit stream on the ALU's data_in1/data_in2,
// and collects the ALU's data_out stream back into bytes for memory.
// Sits between the memory interface and the ALU; gates ALU advance until the
// operand is present.
// PARAMETERS
// REG_BITS  8  register/byte width; bus width of in_data/out_data
// NSHIFT    2  bits per ALU step; must divide REG_BITS
// PORTS
// clk           in   1         clock
// reset         in   1         synchronous, active-high
// cmd_valid     in   1         new transfer request
// cmd_ready     out  1         high only in IDLE
// cmd_pair      in   1         1: 16-bit (2 bytes), 0: 8-bit
// cmd_fetch     in   1         1: operand bytes must be fetched on in_*
// cmd_store     in   1         1: captured result bytes are emitted on out_*
// in_valid      in   1         operand byte valid
// in_ready      out  1         operand byte accepted
// in_data       in   REG_BITS  operand byte, low byte first
// out_valid     out  1         result byte valid
// out_ready     in   1         result byte taken
// out_data      out  REG_BITS  result byte, low byte first
// stream_ready  out  1         operand loaded; ALU may assert advance
// active        in   1         ALU active strobe: one NSHIFT chunk per cycle
// op_done       in   1         ALU last step of op
// data_in       out  NSHIFT    chunk to ALU data_in1/data_in2
// data_out      in   NSHIFT    chunk from ALU data_out
// err           out  1         sticky: protocol violation
// BEHAVIOUR
// - State: IDLE, FETCH, STREAM, DRAIN. Reset (any cycle, including mid-transfer)
//   -> IDLE. Reset clears shift registers, counters, and err. All outputs read 0,
//   except cmd_ready=1.
// - Length: N = cmd_pair ? 2 : 1 bytes; S = N*REG_BITS/NSHIFT steps, latched
//   on cmd accept.
// - IDLE: cmd_valid&&cmd_ready accepts. Next state is FETCH if cmd_fetch,
//   else STREAM.
// - FETCH: in_ready=1. Each in_valid&&in_ready writes in_data into byte slot
//   byte_cnt. After N bytes -> STREAM. Never accepts more than N bytes.
// - STREAM: stream_ready=1. data_in = operand[NSHIFT-1:0] combinationally.
//   On active: operand >>= NSHIFT (zero fill at the top);
//   result = {data_out, result[2*REG_BITS-1:NSHIFT]}; step_cnt++.
// - STREAM exit: op_done&&active -> DRAIN if cmd_store, else IDLE.
//   If step_cnt+1 != S at that cycle, set err; the exit happens anyway.
// - STREAM data without fetch: when entered with cmd_fetch=0, data_in is 0.
// - Active outside STREAM: sets err and is otherwise ignored.
// - Result alignment: for N=1 the captured byte is result[2*REG_BITS-1:REG_BITS];
//   the block realigns it so out_data carries it.
// - DRAIN: out_valid=1 and out_data = current byte, low byte first.
//   Advance on out_valid&&out_ready. After N bytes -> IDLE.
//   out_data holds stable while out_valid&&!out_ready.
// - Latency: cmd accept -> FETCH/STREAM next cycle. Last in byte -> stream_ready
//   next cycle. op_done -> first out_valid next cycle. Last out handshake ->
//   cmd_ready next cycle.
// - Counters: step_cnt is $clog2(2*REG_BITS/NSHIFT)+1 bits; byte_cnt is 2 bits.
//   Both clear on entry to each state. There is no wrap-around.
// - Simultaneous events: cmd_valid outside IDLE is ignored; it is not queued.
//   in_valid outside FETCH is ignored (in_ready=0).
// STRUCTURE
// - Shared package/header: state encoding localparams ST_IDLE..ST_DRAIN,
//   default REG_BITS/NSHIFT. Add these to common.vh next to the OP_* defines.
// - One natural sub-module: serial_shift_reg (parallel byte load, NSHIFT-bit
//   shift with enable), instanced twice: operand out, result in.
// - FSM and counters stay in this module. No combinational path from in_data
//   to out_data.
// TESTING
// - 8-bit fetch+store: cmd_pair=0, in_data=8'hB4, ALU loopback (data_out=data_in)
//   -> data_in = 0,1,3,2 over 4 actives; out_data=8'hB4; cmd_ready returns.
// - 16-bit: bytes 8'h34 then 8'h12, loopback -> 8 chunks 0,1,3,0,2,0,1,0;
//   outputs 8'h34 then 8'h12.
// - Backpressure: out_ready low 5 cycles in DRAIN -> out_valid held and
//   out_data stable; no byte lost.
// - Stalls: in_valid gaps in FETCH and active gaps in STREAM -> same result
//   as the no-stall run; stream_ready is 0 until the last byte is accepted.
// - Protocol error: op_done after 3 actives with S=4 -> err=1 and IDLE;
//   active in IDLE -> err=1.
// - Reset mid-STREAM, then a fresh 8-bit transfer of 8'h5A -> all outputs 0,
//   err=0, cmd_ready=1; transfer yields out_data=8'h5A.

Source files
------------

// File: rtl/alu_serial_port_pkg.sv
// rtl/alu_serial_port_pkg.sv - shared state encoding and default widths for the ALU serial port
package alu_serial_port_pkg;

    localparam int DEF_REG_BITS = 8;
    localparam int DEF_NSHIFT   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_serial_port_shift.sv
// rtl/alu_serial_port_shift.sv - two-byte register with byte-slot load and LSB-out NSHIFT-bit shift
module serial_shift_reg #(
    parameter int BYTE_W = 8,
    parameter int NSHIFT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  load_en_i,
    input  logic                  load_slot_i,
    input  logic [BYTE_W-1:0]     load_byte_i,
    input  logic                  shift_en_i,
    input  logic [NSHIFT-1:0]     shift_in_i,
    output logic [2*BYTE_W-1:0]   data_o
);

    logic [2*BYTE_W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (clear_i) begin
            data_d = '0;
        end else if (load_en_i) begin
            if (load_slot_i) begin
                data_d[2*BYTE_W-1:BYTE_W] = load_byte_i;
            end else begin
                data_d[BYTE_W-1:0] = load_byte_i;
            end
        end else if (shift_en_i) begin
            // New chunk enters at the top so the first chunk ends up in the low bits.
            data_d = {shift_in_i, data_q[2*BYTE_W-1:NSHIFT]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/alu_serial_port.sv
// rtl/alu_serial_port.sv - byte <-> NSHIFT-bit serial bridge between memory and the ALU datapath
module alu_serial_port
    import alu_serial_port_pkg::*;
#(
    parameter int REG_BITS = DEF_REG_BITS,
    parameter int NSHIFT   = DEF_NSHIFT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_pair,
    input  logic                cmd_fetch,
    input  logic                cmd_store,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [REG_BITS-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [REG_BITS-1:0] out_data,
    output logic                stream_ready,
    input  logic                active,
    input  logic                op_done,
    output logic [NSHIFT-1:0]   data_in,
    input  logic [NSHIFT-1:0]   data_out,
    output logic                err
);

    localparam int W      = 2 * REG_BITS;
    localparam int STEP_W = $clog2(W / NSHIFT) + 1;

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic                pair_q, pair_d;
    logic                store_q, store_d;
    logic                err_q, err_d;

    logic                op_clear, op_load, op_shift;
    logic                res_clear, res_shift;
    logic [1:0]          nbytes;
    logic [W-1:0]        operand_q;
    logic [W-1:0]        result_q;
    logic                unused_operand_hi;

    assign nbytes = pair_q ? 2'd2 : 2'd1;

    always_comb begin
        state_d      = state_q;
        step_cnt_d   = step_cnt_q;
        steps_d      = steps_q;
        byte_cnt_d   = byte_cnt_q;
        pair_d       = pair_q;
        store_d      = store_q;
        err_d        = err_q;
        cmd_ready    = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        stream_ready = 1'b0;
        op_clear     = 1'b0;
        op_load      = 1'b0;
        op_shift     = 1'b0;
        res_clear    = 1'b0;
        res_shift    = 1'b0;

        if (active && (state_q != ST_STREAM)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    pair_d     = cmd_pair;
                    store_d    = cmd_store;
                    steps_d    = cmd_pair ? STEP_W'(W / NSHIFT) : STEP_W'(REG_BITS / NSHIFT);
                    op_clear   = 1'b1;
                    res_clear  = 1'b1;
                    byte_cnt_d = '0;
                    step_cnt_d = '0;
                    state_d    = cmd_fetch ? ST_FETCH : ST_STREAM;
                end
            end
            ST_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_load    = 1'b1;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if ((byte_cnt_q + 2'd1) == nbytes) begin
                        byte_cnt_d = '0;
                        step_cnt_d = '0;
                        state_d    = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                stream_ready = 1'b1;
                if (active) begin
                    op_shift  = 1'b1;
                    res_shift = 1'b1;
                    if (step_cnt_q != '1) begin
                        step_cnt_d = step_cnt_q + STEP_W'(1);
                    end
                    if (op_done) begin
                        // A short or long op still exits; the mismatch is only flagged.
                        if ((step_cnt_q + STEP_W'(1)) != steps_q) begin
                            err_d = 1'b1;
                        end
                        byte_cnt_d = '0;
                        step_cnt_d = '0;
                        state_d    = store_q ? ST_DRAIN : ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if ((byte_cnt_q + 2'd1) == nbytes) begin
                        byte_cnt_d = '0;
                        step_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            step_cnt_q <= '0;
            steps_q    <= '0;
            byte_cnt_q <= '0;
            pair_q     <= 1'b0;
            store_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            steps_q    <= steps_d;
            byte_cnt_q <= byte_cnt_d;
            pair_q     <= pair_d;
            store_q    <= store_d;
            err_q      <= err_d;
        end
    end

    serial_shift_reg #(
        .BYTE_W (REG_BITS),
        .NSHIFT (NSHIFT)
    ) u_operand (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (op_clear),
        .load_en_i   (op_load),
        .load_slot_i (byte_cnt_q[0]),
        .load_byte_i (in_data),
        .shift_en_i  (op_shift),
        .shift_in_i  ({NSHIFT{1'b0}}),
        .data_o      (operand_q)
    );

    serial_shift_reg #(
        .BYTE_W (REG_BITS),
        .NSHIFT (NSHIFT)
    ) u_result (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (res_clear),
        .load_en_i   (1'b0),
        .load_slot_i (1'b0),
        .load_byte_i ({REG_BITS{1'b0}}),
        .shift_en_i  (res_shift),
        .shift_in_i  (data_out),
        .data_o      (result_q)
    );

    assign unused_operand_hi = ^operand_q[W-1:NSHIFT];

    assign data_in = (state_q == ST_STREAM) ? operand_q[NSHIFT-1:0] : '0;

    // A single byte lands in the upper half after REG_BITS/NSHIFT shifts.
    always_comb begin
        out_data = '0;
        if (state_q == ST_DRAIN) begin
            if (pair_q && (byte_cnt_q == 2'd0)) begin
                out_data = result_q[REG_BITS-1:0];
            end else begin
                out_data = result_q[W-1:REG_BITS];
            end
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_alu_serial_port.sv
// tb/tb_alu_serial_port.sv - self-checking bench for alu_serial_port with ALU loopback model
module tb_alu_serial_port;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_pair, cmd_fetch, cmd_store;
    logic       in_valid, in_ready;
    logic [7:0] in_data;
    logic       out_valid, out_ready;
    logic [7:0] out_data;
    logic       stream_ready, active, op_done;
    logic [1:0] data_in, data_out;
    logic       err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign data_out = data_in;

    alu_serial_port dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_pair     (cmd_pair),
        .cmd_fetch    (cmd_fetch),
        .cmd_store    (cmd_store),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .stream_ready (stream_ready),
        .active       (active),
        .op_done      (op_done),
        .data_in      (data_in),
        .data_out     (data_out),
        .err          (err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".cmd_ready"}, 16'(cmd_ready), 16'd1);
        chk({tag, ".in_ready"}, 16'(in_ready), 16'd0);
        chk({tag, ".out_valid"}, 16'(out_valid), 16'd0);
        chk({tag, ".out_data"}, 16'(out_data), 16'd0);
        chk({tag, ".stream_ready"}, 16'(stream_ready), 16'd0);
        chk({tag, ".data_in"}, 16'(data_in), 16'd0);
    endtask

    // Reference: operand is the fetched bytes (or zero), streamed LSB-first in 2-bit
    // chunks; with data_out looped back the result bytes equal the operand bytes.
    task automatic run_xfer(input logic pair, input logic fetch, input logic store,
                            input logic [15:0] val, input int max_gap, input int out_hold);
        int          n;
        int          s;
        int          g;
        logic [15:0] opv;
        n   = pair ? 2 : 1;
        s   = n * 4;
        opv = fetch ? (pair ? val : {8'h00, val[7:0]}) : 16'h0000;

        #1;
        chk("xfer.cmd_ready_idle", 16'(cmd_ready), 16'd1);
        cmd_valid = 1'b1;
        cmd_pair  = pair;
        cmd_fetch = fetch;
        cmd_store = store;
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("xfer.cmd_ready_busy", 16'(cmd_ready), 16'd0);

        if (fetch) begin
            for (int j = 0; j < n; j++) begin
                g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
                for (int k = 0; k < g; k++) begin
                    in_valid = 1'b0;
                    #1;
                    chk("fetch.in_ready", 16'(in_ready), 16'd1);
                    chk("fetch.stream_ready_gap", 16'(stream_ready), 16'd0);
                    tick();
                end
                in_valid = 1'b1;
                in_data  = opv[8*j +: 8];
                #1;
                chk("fetch.stream_ready_low", 16'(stream_ready), 16'd0);
                tick();
            end
            in_valid = 1'b0;
        end

        #1;
        chk("stream.ready", 16'(stream_ready), 16'd1);
        for (int k = 0; k < s; k++) begin
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int q = 0; q < g; q++) begin
                active = 1'b0;
                #1;
                chk("stream.ready_gap", 16'(stream_ready), 16'd1);
                tick();
            end
            active  = 1'b1;
            op_done = (k == s - 1);
            #1;
            chk($sformatf("stream.chunk%0d", k), 16'(data_in), (opv >> (2 * k)) & 16'h0003);
            tick();
        end
        active  = 1'b0;
        op_done = 1'b0;

        if (store) begin
            for (int j = 0; j < n; j++) begin
                g = (out_hold >= 0) ? out_hold : int'($urandom_range(0, 2));
                if (j > 0 && out_hold >= 0) g = 0;
                for (int q = 0; q < g; q++) begin
                    out_ready = 1'b0;
                    #1;
                    chk("drain.valid_held", 16'(out_valid), 16'd1);
                    chk("drain.data_stable", 16'(out_data), 16'(opv[8*j +: 8]));
                    tick();
                end
                out_ready = 1'b1;
                #1;
                chk("drain.valid", 16'(out_valid), 16'd1);
                chk($sformatf("drain.byte%0d", j), 16'(out_data), 16'(opv[8*j +: 8]));
                tick();
            end
            out_ready = 1'b0;
        end

        #1;
        chk("xfer.cmd_ready_return", 16'(cmd_ready), 16'd1);
        chk("xfer.out_valid_off", 16'(out_valid), 16'd0);
        chk("xfer.err_clear", 16'(err), 16'd0);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_pair  = 1'b0;
        cmd_fetch = 1'b0;
        cmd_store = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        active    = 1'b0;
        op_done   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk_idle("reset");
        chk("reset.err", 16'(err), 16'd0);

        in_valid = 1'b1;
        #1;
        chk("idle.in_ready_ignored", 16'(in_ready), 16'd0);
        in_valid = 1'b0;

        run_xfer(1'b0, 1'b1, 1'b1, 16'h00B4, 0, 0);
        run_xfer(1'b1, 1'b1, 1'b1, 16'h1234, 0, 0);
        run_xfer(1'b1, 1'b1, 1'b1, 16'hC3A9, 0, 5);
        run_xfer(1'b0, 1'b1, 1'b1, 16'h00B4, 3, -1);
        run_xfer(1'b1, 1'b0, 1'b1, 16'hFFFF, 1, -1);

        // Short op: op_done on the third of four steps.
        cmd_valid = 1'b1; cmd_pair = 1'b0; cmd_fetch = 1'b1; cmd_store = 1'b0;
        tick();
        cmd_valid = 1'b0;
        in_valid  = 1'b1; in_data = 8'h77;
        tick();
        in_valid  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            active  = 1'b1;
            op_done = (k == 2);
            tick();
        end
        active  = 1'b0;
        op_done = 1'b0;
        #1;
        chk("short_op.err", 16'(err), 16'd1);
        chk("short_op.idle", 16'(cmd_ready), 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("short_op.err_cleared", 16'(err), 16'd0);

        active = 1'b1;
        tick();
        active = 1'b0;
        #1;
        chk("idle_active.err", 16'(err), 16'd1);
        chk("idle_active.cmd_ready", 16'(cmd_ready), 16'd1);
        tick();
        #1;
        chk("idle_active.err_sticky", 16'(err), 16'd1);

        // Reset in the middle of streaming.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cmd_valid = 1'b1; cmd_pair = 1'b1; cmd_fetch = 1'b1; cmd_store = 1'b1;
        tick();
        cmd_valid = 1'b0;
        in_valid  = 1'b1; in_data = 8'hA5;
        tick();
        in_data   = 8'h3C;
        tick();
        in_valid  = 1'b0;
        active    = 1'b1;
        tick();
        tick();
        active    = 1'b0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        #1;
        chk_idle("mid_reset");
        chk("mid_reset.err", 16'(err), 16'd0);
        run_xfer(1'b0, 1'b1, 1'b1, 16'h005A, 0, 0);

        for (int i = 0; i < 20; i++) begin
            run_xfer(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 3) != 0), 16'($urandom), 2, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
